fetch_stage: RTL and testbench

//  IF stage: PC register, next-PC select and IF/ID pipeline register.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/pc_reg.sv | 26 ++
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: bubble encoding, reset PC, PC step and
// the fetch FSM state type.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [63:0] RESET_PC  = 64'h0;
  localparam int          PC_INC    = 4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register. Priority is rst > load > hold > increment;
// increment wraps modulo 2^PC_W.
module pc_reg #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            load,
  input  logic [PC_W-1:0] load_pc,
  output logic [PC_W-1:0] pc
);
  import cpu_pkg::*;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (!hold) begin
      pc <= pc + PC_W'(PC_INC);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: fetch FSM, PC (via pc_reg), IF/ID pipeline register and the
// fetch/stall performance counters. fetch_state exposes the FSM for debug.
module fetch_stage #(
  parameter int                 PC_W      = 64,
  parameter int                 INSTR_W   = 32,
  parameter logic [PC_W-1:0]    RESET_PC  = PC_W'(cpu_pkg::RESET_PC),
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(cpu_pkg::NOP_INSTR),
  parameter int                 CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prevent_update_pc,
  input  logic               prevent_update_if_id,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_id_valid,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [4:0]         if_id_rs1,
  output logic [4:0]         if_id_rs2,
  output logic [CNT_W-1:0]   fetch_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic               fetch_state
);
  import cpu_pkg::*;

  fetch_state_e    state_q, state_d;
  logic            run;
  logic            pc_load, pc_hold;
  logic            if_flush, if_load, stall_any;
  logic [PC_W-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // BOOT is a single dead cycle after reset; RUN is left only through rst.
  always_comb begin
    state_d = state_q;
    imem_en = 1'b0;
    run     = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        imem_en = 1'b1;
        run     = 1'b1;
      end
      default: state_d = BOOT;
    endcase
  end

  // A redirect wins over both stalls; the stalls act independently.
  assign pc_load   = run & redirect_valid;
  assign pc_hold   = ~run | prevent_update_pc;
  assign if_flush  = ~run | redirect_valid;
  assign if_load   = run & ~redirect_valid & ~prevent_update_if_id;
  assign stall_any = run & ~redirect_valid & (prevent_update_pc | prevent_update_if_id);

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .hold    (pc_hold),
    .load    (pc_load),
    .load_pc (redirect_target),
    .pc      (pc_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      fetch_cnt   <= '0;
    end else if (if_flush) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
    end else if (if_load) begin
      if_id_valid <= 1'b1;
      if_id_pc    <= pc_q;
      if_id_instr <= imem_rdata;
      fetch_cnt   <= fetch_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            stall_cnt <= '0;
    else if (stall_any) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign imem_addr   = pc_q;
  assign if_id_rs1   = if_id_instr[19:15];
  assign if_id_rs2   = if_id_instr[24:20];
  assign fetch_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + random bench for fetch_stage: a cycle model predicts each IF/ID
// load into a scoreboard queue that is popped after every clock edge.
module tb_fetch_stage;
  localparam int W = 97;  // {valid, pc[63:0], instr[31:0]}

  logic        clk;
  logic        rst;
  logic        prevent_update_pc;
  logic        prevent_update_if_id;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic [63:0] imem_addr, imem_addr_s;
  logic        imem_en, imem_en_s;
  logic [31:0] imem_rdata, imem_rdata_s;
  logic        if_id_valid, if_id_valid_s;
  logic [63:0] if_id_pc, if_id_pc_s;
  logic [31:0] if_id_instr, if_id_instr_s;
  logic [4:0]  if_id_rs1, if_id_rs1_s, if_id_rs2, if_id_rs2_s;
  logic [31:0] fetch_cnt, stall_cnt;
  logic [3:0]  fetch_cnt_s, stall_cnt_s;
  logic        fetch_state, fetch_state_s;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  // reference model state
  logic        m_known = 1'b0;
  logic        m_run;
  logic [63:0] m_pc, m_ipc;
  logic        m_v;
  logic [31:0] m_instr, m_fetch, m_stall;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0003;
  endfunction

  assign imem_rdata   = instr_of(imem_addr);
  assign imem_rdata_s = instr_of(imem_addr_s);

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .prevent_update_pc(prevent_update_pc), .prevent_update_if_id(prevent_update_if_id),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .fetch_state(fetch_state)
  );

  // narrow-counter instance with identical stimulus exercises counter wrap
  fetch_stage #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst),
    .prevent_update_pc(prevent_update_pc), .prevent_update_if_id(prevent_update_if_id),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr_s), .imem_en(imem_en_s), .imem_rdata(imem_rdata_s),
    .if_id_valid(if_id_valid_s), .if_id_pc(if_id_pc_s), .if_id_instr(if_id_instr_s),
    .if_id_rs1(if_id_rs1_s), .if_id_rs2(if_id_rs2_s),
    .fetch_cnt(fetch_cnt_s), .stall_cnt(stall_cnt_s), .fetch_state(fetch_state_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, predict, push, clock, pop and compare
  task automatic step(input logic r, input logic pup, input logic pui,
                      input logic rv, input logic [63:0] tgt);
    logic [W-1:0] e;
    logic [31:0]  rd;
    rst = r;
    prevent_update_pc = pup;
    prevent_update_if_id = pui;
    redirect_valid = rv;
    redirect_target = tgt;
    #1;
    if (m_known) begin
      chk("imem_en", {63'b0, imem_en}, {63'b0, m_run});
      chk("imem_addr", imem_addr, m_pc);
    end
    rd = instr_of(m_pc);
    if (r) begin
      m_run = 1'b0; m_pc = 64'h0; m_v = 1'b0; m_ipc = 64'h0;
      m_instr = 32'h0000_0013; m_fetch = 32'h0; m_stall = 32'h0;
      m_known = 1'b1;
    end else if (!m_run) begin
      m_run = 1'b1;
    end else if (rv) begin
      m_pc = tgt; m_v = 1'b0; m_ipc = 64'h0; m_instr = 32'h0000_0013;
    end else begin
      if (pup || pui) m_stall = m_stall + 32'd1;
      if (!pui) begin
        m_v = 1'b1; m_ipc = m_pc; m_instr = rd; m_fetch = m_fetch + 32'd1;
      end
      if (!pup) m_pc = m_pc + 64'd4;
    end
    exp_q.push_back({m_v, m_ipc, m_instr});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("if_id_valid", {63'b0, if_id_valid}, {63'b0, e[96]});
    chk("if_id_pc", if_id_pc, e[95:32]);
    chk("if_id_instr", {32'b0, if_id_instr}, {32'b0, e[31:0]});
    chk("if_id_rs1", {59'b0, if_id_rs1}, {59'b0, e[19:15]});
    chk("if_id_rs2", {59'b0, if_id_rs2}, {59'b0, e[24:20]});
    chk("pc", imem_addr, m_pc);
    chk("state", {63'b0, fetch_state}, {63'b0, m_run});
    chk("fetch_cnt", {32'b0, fetch_cnt}, {32'b0, m_fetch});
    chk("stall_cnt", {32'b0, stall_cnt}, {32'b0, m_stall});
    chk("fetch_cnt_w4", {60'b0, fetch_cnt_s}, {60'b0, m_fetch[3:0]});
    chk("stall_cnt_w4", {60'b0, stall_cnt_s}, {60'b0, m_stall[3:0]});
  endtask

  initial begin
    rst = 1'b1;
    prevent_update_pc = 1'b0;
    prevent_update_if_id = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 64'h0;

    // reset for two cycles, then the BOOT dead cycle
    step(1, 0, 0, 0, 64'h0);
    step(1, 0, 0, 0, 64'h0);
    chk("reset_instr", {32'b0, if_id_instr}, 64'h13);
    step(0, 0, 0, 0, 64'h0);
    chk("boot_en", {63'b0, imem_en}, 64'h1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 64'h0);
    chk("seq_fetch_cnt", {32'b0, fetch_cnt}, 64'd4);

    // load-use stall at pc 0x10
    step(0, 1, 1, 0, 64'h0);
    chk("stall_pc_hold", imem_addr, 64'h10);
    chk("stall_ifid_hold", if_id_pc, 64'hC);
    chk("stall_cnt_one", {32'b0, stall_cnt}, 64'd1);
    step(0, 0, 0, 0, 64'h0);
    chk("after_stall_ifid", if_id_pc, 64'h10);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 64'h0);

    // redirect at pc 0x20
    chk("pre_redirect_pc", imem_addr, 64'h20);
    step(0, 0, 0, 1, 64'h200);
    chk("redir_pc", imem_addr, 64'h200);
    chk("redir_bubble", {32'b0, if_id_instr}, 64'h13);
    step(0, 0, 0, 0, 64'h0);
    chk("redir_ifid_pc", if_id_pc, 64'h200);
    step(0, 0, 0, 0, 64'h0);

    // redirect overrides simultaneous stalls
    step(0, 1, 1, 1, 64'h80);
    chk("redir_stall_pc", imem_addr, 64'h80);
    step(0, 0, 0, 0, 64'h0);
    step(0, 0, 0, 0, 64'h0);

    // independent stalls, then an unaligned redirect
    step(0, 1, 0, 0, 64'h0);
    step(0, 1, 0, 0, 64'h0);
    step(0, 0, 1, 0, 64'h0);
    step(0, 0, 1, 0, 64'h0);
    step(0, 0, 0, 1, 64'h1235);
    step(0, 0, 0, 0, 64'h0);

    // PC wrap
    step(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 0, 64'h0);
    chk("pc_wrap", imem_addr, 64'h0);
    step(0, 0, 0, 0, 64'h0);

    // randomized mix
    for (int i = 0; i < 60; i++)
      step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, {32'h0, $urandom});

    // reset while stalled and redirecting
    step(1, 1, 1, 1, 64'h400);
    chk("midrst_state", {63'b0, fetch_state}, 64'h0);
    chk("midrst_cnt", {32'b0, fetch_cnt}, 64'h0);
    step(0, 1, 1, 1, 64'h400);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
